// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode, ALU, state and select encodings for the multicycle CPU
package cpu_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_LD   = 4'h5,
        OP_ST   = 4'h6,
        OP_JMP  = 4'h7,
        OP_INC  = 4'h8,
        OP_HALT = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011
    } alu_op_e;

    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_FETCH1 = 4'd1;
    localparam logic [3:0] ST_FETCH2 = 4'd2;
    localparam logic [3:0] ST_DECODE = 4'd3;
    localparam logic [3:0] ST_EXEC   = 4'd4;
    localparam logic [3:0] ST_MEMRD  = 4'd5;
    localparam logic [3:0] ST_LDWB   = 4'd6;
    localparam logic [3:0] ST_MEMWR  = 4'd7;
    localparam logic [3:0] ST_JUMP   = 4'd8;
    localparam logic [3:0] ST_HALT   = 4'd9;

    typedef enum logic [3:0] {
        CS_IDLE   = ST_IDLE,
        CS_FETCH1 = ST_FETCH1,
        CS_FETCH2 = ST_FETCH2,
        CS_DECODE = ST_DECODE,
        CS_EXEC   = ST_EXEC,
        CS_MEMRD  = ST_MEMRD,
        CS_LDWB   = ST_LDWB,
        CS_MEMWR  = ST_MEMWR,
        CS_JUMP   = ST_JUMP,
        CS_HALT   = ST_HALT
    } ctrl_state_e;

    // pcSelect/adrSelect pick pc-side (0) or ir2 (1); wd3Select picks memRD (0) or aluOut (1)
    localparam logic SEL_PC  = 1'b0;
    localparam logic SEL_IR2 = 1'b1;
    localparam logic SEL_MEM = 1'b0;
    localparam logic SEL_ALU = 1'b1;

    typedef struct packed {
        logic       pcSelect;
        logic       pcEnable;
        logic       adrSelect;
        logic       ir1En;
        logic       ir2En;
        logic       regSelect;
        logic       wd3Select;
        logic       regWrite;
        logic       op1Sel;
        logic       op2Sel;
        logic [2:0] aluControl;
        logic       memWrite;
        logic       halted;
    } ctrl_word_t;

    function automatic alu_op_e alu_for(input opcode_e op);
        case (op)
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational state to control-word decode for the multicycle controller
module ctrl_decode
    import cpu_pkg::*;
(
    input  logic [3:0]  state,
    input  alu_op_e     alu_op,
    input  logic        op2_const,
    output ctrl_word_t  cw
);

    always_comb begin
        cw = '0;
        case (state)
            ST_FETCH1, ST_FETCH2: begin
                // pc <- pc + 1 while the addressed byte lands in ir1 or ir2
                cw.adrSelect  = SEL_PC;
                cw.op1Sel     = 1'b0;
                cw.op2Sel     = 1'b1;
                cw.aluControl = ALU_ADD;
                cw.pcEnable   = 1'b1;
                cw.ir1En      = (state == ST_FETCH1);
                cw.ir2En      = (state == ST_FETCH2);
            end
            ST_EXEC: begin
                cw.op1Sel     = 1'b1;
                cw.op2Sel     = op2_const;
                cw.aluControl = alu_op;
                cw.wd3Select  = SEL_ALU;
                cw.regWrite   = 1'b1;
            end
            ST_MEMRD: begin
                cw.adrSelect  = SEL_IR2;
            end
            ST_LDWB: begin
                cw.adrSelect  = SEL_IR2;
                cw.wd3Select  = SEL_MEM;
                cw.regWrite   = 1'b1;
            end
            ST_MEMWR: begin
                cw.adrSelect  = SEL_IR2;
                cw.memWrite   = 1'b1;
            end
            ST_JUMP: begin
                cw.pcSelect   = SEL_IR2;
                cw.pcEnable   = 1'b1;
            end
            ST_HALT: begin
                cw.halted     = 1'b1;
            end
            default: cw = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - Moore FSM sequencing the 8-bit multicycle datapath; MULTICYCLE_CONTROLLER_ILLEGAL_TRAP_EN traps opcodes 9..E
module multicycle_controller
    import cpu_pkg::*;
#(
    parameter int RESET_PC_HOLD = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] opcode,
    output logic       pcSelect,
    output logic       pcEnable,
    output logic       adrSelect,
    output logic       ir1En,
    output logic       ir2En,
    output logic       regSelect,
    output logic       wd3Select,
    output logic       regWrite,
    output logic       op1Sel,
    output logic       op2Sel,
    output logic [2:0] aluControl,
    output logic       memWrite,
    output logic       halted,
    output logic       illegal
);

    logic [3:0] state, next_state;
    logic [3:0] count;
    alu_op_e    alu_q;
    logic       inc_q;
    ctrl_word_t cw;
    logic       is_undef;

    assign is_undef = (opcode >= 4'h9) && (opcode <= 4'hE);

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (count == 4'(RESET_PC_HOLD - 1)) next_state = ST_FETCH1;
            ST_FETCH1: next_state = ST_FETCH2;
            ST_FETCH2: next_state = ST_DECODE;
            ST_DECODE: begin
                case (opcode_e'(opcode))
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_INC: next_state = ST_EXEC;
                    OP_LD:   next_state = ST_MEMRD;
                    OP_ST:   next_state = ST_MEMWR;
                    OP_JMP:  next_state = ST_JUMP;
                    OP_HALT: next_state = ST_HALT;
                    default: next_state = ST_FETCH1;
                endcase
`ifdef MULTICYCLE_CONTROLLER_ILLEGAL_TRAP_EN
                if (is_undef) next_state = ST_HALT;
`endif
            end
            ST_MEMRD:  next_state = ST_LDWB;
            ST_HALT:   next_state = ST_HALT;
            default:   next_state = ST_FETCH1;
        endcase
    end

    // ALU selection is latched in DECODE so EXEC outputs depend only on registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            count <= '0;
            alu_q <= ALU_ADD;
            inc_q <= 1'b0;
        end else begin
            state <= next_state;
            if (state == ST_IDLE) count <= count + 4'd1;
            if (state == ST_DECODE) begin
                alu_q <= alu_for(opcode_e'(opcode));
                inc_q <= (opcode == OP_INC);
            end
        end
    end

`ifdef MULTICYCLE_CONTROLLER_ILLEGAL_TRAP_EN
    logic illegal_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            illegal_q <= 1'b0;
        else if (state == ST_DECODE && is_undef)
            illegal_q <= 1'b1;
    end
    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
    logic unused_undef;
    assign unused_undef = is_undef;
`endif

    ctrl_decode u_decode (
        .state     (state),
        .alu_op    (alu_q),
        .op2_const (inc_q),
        .cw        (cw)
    );

    assign pcSelect   = cw.pcSelect;
    assign pcEnable   = cw.pcEnable;
    assign adrSelect  = cw.adrSelect;
    assign ir1En      = cw.ir1En;
    assign ir2En      = cw.ir2En;
    assign regSelect  = cw.regSelect;
    assign wd3Select  = cw.wd3Select;
    assign regWrite   = cw.regWrite;
    assign op1Sel     = cw.op1Sel;
    assign op2Sel     = cw.op2Sel;
    assign aluControl = cw.aluControl;
    assign memWrite   = cw.memWrite;
    assign halted     = cw.halted;

    a_one_strobe: assert property (@(posedge clk) disable iff (!reset)
        $onehot0({pcEnable, regWrite, memWrite}));

endmodule
